// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding, load-use / scoreboard hazard detection and
// long-latency destination scoreboard with a saturating stall counter.
module forwarding_hazard_unit #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned SEL_W       = $clog2(NUM_FWD + 2),
  localparam int unsigned CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*5-1:0]     rs_ex,
  input  logic [NUM_SRC-1:0]       rs_used_ex,
  input  logic [NUM_FWD*5-1:0]     rd_fwd,
  input  logic [NUM_FWD-1:0]       reg_write_fwd,
  input  logic [NUM_FWD-1:0]       data_ready_fwd,
  input  logic                     issue_long,
  input  logic [4:0]               issue_rd,
  input  logic                     lw_valid,
  input  logic [4:0]               lw_rd,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      busy_mask,
  output logic [CNT_W-1:0]         pending_count,
  output logic [31:0]              stall_cycles,
  output logic                     sb_error
);

  logic [NUM_REGS-1:0] busy_next;
  logic                src_stall;
  logic                waw_stall;
  logic                struct_stall;
  logic                sb_set;
  logic                sb_clear;
  logic                sb_orphan;

  // Addresses beyond NUM_REGS are treated as never busy.
  function automatic logic is_busy(input logic [4:0] r, input logic [NUM_REGS-1:0] mask);
    logic b;
    b = 1'b0;
    for (int unsigned j = 0; j < NUM_REGS; j++) begin
      if (32'(r) == j) b = mask[j];
    end
    return b;
  endfunction

  always_comb begin
    pending_count = '0;
    for (int unsigned j = 0; j < NUM_REGS; j++) begin
      pending_count = pending_count + CNT_W'(busy_mask[j]);
    end
  end

  always_comb begin
    logic [4:0]       rs;
    logic             hit;
    logic [SEL_W-1:0] sel;
    fwd_sel   = '0;
    src_stall = 1'b0;
    rs        = '0;
    hit       = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rs  = rs_ex[5*i +: 5];
      hit = 1'b0;
      sel = '0;
      if (rs_used_ex[i] && rs != 5'd0) begin
        // Youngest matching stage decides; an unready match stalls rather than
        // falling through to an older stage.
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
          if (!hit && reg_write_fwd[k] && rd_fwd[5*k +: 5] == rs) begin
            hit = 1'b1;
            if (data_ready_fwd[k]) sel = SEL_W'(k + 1);
            else                   src_stall = 1'b1;
          end
        end
        if (!hit) begin
          if (lw_valid && lw_rd == rs)   sel = SEL_W'(NUM_FWD + 1);
          else if (is_busy(rs, busy_mask)) src_stall = 1'b1;
        end
      end
      if (!rst) fwd_sel[SEL_W*i +: SEL_W] = sel;
    end
  end

  always_comb begin
    waw_stall    = issue_long && issue_rd != 5'd0 && is_busy(issue_rd, busy_mask);
    struct_stall = issue_long && pending_count == CNT_W'(MAX_PENDING) && !lw_valid;
    stall        = !rst && !flush && (src_stall || waw_stall || struct_stall);
  end

  always_comb begin
    sb_set    = issue_long && !stall && !flush && issue_rd != 5'd0;
    sb_clear  = lw_valid && lw_rd != 5'd0 && is_busy(lw_rd, busy_mask);
    sb_orphan = lw_valid && lw_rd != 5'd0 && !is_busy(lw_rd, busy_mask);
    busy_next = busy_mask;
    for (int unsigned j = 1; j < NUM_REGS; j++) begin
      if (sb_clear && 32'(lw_rd) == j)  busy_next[j] = 1'b0;
      if (sb_set && 32'(issue_rd) == j) busy_next[j] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask    <= '0;
      stall_cycles <= '0;
      sb_error     <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (sb_orphan) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: per-cycle comparison against a
// rule-level model plus hand-computed checkpoints.
module tb_forwarding_hazard_unit;

  localparam int NSRC = 2;
  localparam int NFWD = 2;
  localparam int SELW = 2;
  localparam int MAXP = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NSRC*5-1:0]     rs_ex;
  logic [NSRC-1:0]       rs_used_ex;
  logic [NFWD*5-1:0]     rd_fwd;
  logic [NFWD-1:0]       reg_write_fwd;
  logic [NFWD-1:0]       data_ready_fwd;
  logic                  issue_long;
  logic [4:0]            issue_rd;
  logic                  lw_valid;
  logic [4:0]            lw_rd;
  logic                  flush;
  logic [NSRC*SELW-1:0]  fwd_sel;
  logic                  stall;
  logic [31:0]           busy_mask;
  logic [2:0]            pending_count;
  logic [31:0]           stall_cycles;
  logic                  sb_error;

  forwarding_hazard_unit #(
    .NUM_SRC(NSRC), .NUM_FWD(NFWD), .NUM_REGS(32), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .rs_ex(rs_ex), .rs_used_ex(rs_used_ex),
    .rd_fwd(rd_fwd), .reg_write_fwd(reg_write_fwd), .data_ready_fwd(data_ready_fwd),
    .issue_long(issue_long), .issue_rd(issue_rd), .lw_valid(lw_valid), .lw_rd(lw_rd),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .busy_mask(busy_mask),
    .pending_count(pending_count), .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: set of outstanding registers, stall counter, error flag.
  bit              m_busy[32];
  longint unsigned m_cyc = 0;
  bit              m_err = 1'b0;

  always @(negedge clk) begin
    int          e_sel[NSRC];
    bit          e_stall;
    int          pend;
    int          found;
    int          rs;
    logic [NSRC*SELW-1:0] e_fsel;
    logic [31:0] e_mask;

    e_stall = 1'b0;
    pend = 0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) pend++;
    for (int i = 0; i < NSRC; i++) begin
      e_sel[i] = 0;
      rs = int'(rs_ex[5*i +: 5]);
      if (rs_used_ex[i] && rs != 0) begin
        found = -1;
        for (int k = NFWD - 1; k >= 0; k--)
          if (reg_write_fwd[k] && int'(rd_fwd[5*k +: 5]) == rs) found = k;
        if (found >= 0) begin
          if (data_ready_fwd[found]) e_sel[i] = found + 1;
          else e_stall = 1'b1;
        end else if (lw_valid && int'(lw_rd) == rs) e_sel[i] = NFWD + 1;
        else if (m_busy[rs]) e_stall = 1'b1;
      end
    end
    if (issue_long && issue_rd != 0 && m_busy[issue_rd]) e_stall = 1'b1;
    if (issue_long && pend == MAXP && !lw_valid) e_stall = 1'b1;
    if (flush || rst) e_stall = 1'b0;
    e_fsel = '0;
    if (!rst) for (int i = 0; i < NSRC; i++) e_fsel[SELW*i +: SELW] = SELW'(e_sel[i]);
    e_mask = '0;
    for (int r = 0; r < 32; r++) e_mask[r] = m_busy[r];

    chk("fwd_sel", 64'(fwd_sel), 64'(e_fsel));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("busy_mask", 64'(busy_mask), 64'(e_mask));
    chk("pending_count", 64'(pending_count), 64'(pend));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_cyc));
    chk("sb_error", 64'(sb_error), 64'(m_err));

    // Advance the model to the state the DUT holds after the coming edge.
    if (rst) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_cyc = 0;
      m_err = 1'b0;
    end else begin
      if (lw_valid && lw_rd != 0) begin
        if (m_busy[lw_rd]) m_busy[lw_rd] = 1'b0;
        else m_err = 1'b1;
      end
      if (issue_long && !e_stall && !flush && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (e_stall && m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
    end
  end

  task automatic idle();
    rst = 1'b0; rs_ex = '0; rs_used_ex = '0; rd_fwd = '0; reg_write_fwd = '0;
    data_ready_fwd = '0; issue_long = 1'b0; issue_rd = '0; lw_valid = 1'b0;
    lw_rd = '0; flush = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk); #1; idle();
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic load_use7();
    rd_fwd[4:0] = 5'd7; reg_write_fwd = 2'b01; data_ready_fwd = 2'b00;
    rs_ex[4:0] = 5'd7; rs_used_ex = 2'b01;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); rst = 1'b1; mid(); adv(); rst = 1'b1; mid(); adv();
    mid();
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_pend", 64'(pending_count), 64'd0);
    chk("rst_cyc", 64'(stall_cycles), 64'd0);
    chk("rst_err", 64'(sb_error), 64'd0);
    adv();

    // MEM and WB both write x5: MEM wins.
    rd_fwd = {5'd5, 5'd5}; reg_write_fwd = 2'b11; data_ready_fwd = 2'b11;
    rs_ex[4:0] = 5'd5; rs_used_ex = 2'b01;
    mid(); chk("mem_wins", 64'(fwd_sel[1:0]), 64'd1); chk("mem_wins_stall", 64'(stall), 64'd0);
    adv();
    rd_fwd = {5'd5, 5'd0}; reg_write_fwd = 2'b10; data_ready_fwd = 2'b11;
    rs_ex[4:0] = 5'd5; rs_used_ex = 2'b01;
    mid(); chk("wb_only", 64'(fwd_sel[1:0]), 64'd2);
    adv();
    reg_write_fwd = 2'b11; data_ready_fwd = 2'b11;
    rs_ex = {5'd0, 5'd5}; rs_used_ex = 2'b11;
    mid(); chk("rd_x0", 64'(fwd_sel), 64'd0);
    adv();

    // Load-use on src1, then forwarded from WB.
    rd_fwd[4:0] = 5'd7; reg_write_fwd = 2'b01; data_ready_fwd = 2'b00;
    rs_ex[9:5] = 5'd7; rs_used_ex = 2'b10;
    mid(); chk("lu_stall", 64'(stall), 64'd1); chk("lu_sel", 64'(fwd_sel[3:2]), 64'd0);
    adv();
    rd_fwd[9:5] = 5'd7; reg_write_fwd = 2'b10; data_ready_fwd = 2'b10;
    rs_ex[9:5] = 5'd7; rs_used_ex = 2'b10;
    mid(); chk("lu_wb_sel", 64'(fwd_sel[3:2]), 64'd2); chk("lu_wb_stall", 64'(stall), 64'd0);
    chk("lu_cyc", 64'(stall_cycles), 64'd1);
    adv();

    // Long-latency x9: RAW stalls, then lw bypass.
    issue_long = 1'b1; issue_rd = 5'd9;
    mid(); chk("iss9_stall", 64'(stall), 64'd0);
    adv();
    rs_ex[4:0] = 5'd9; rs_used_ex = 2'b01;
    mid(); chk("busy9", 64'(busy_mask[9]), 64'd1); chk("raw9", 64'(stall), 64'd1);
    adv();
    rs_ex[4:0] = 5'd9; rs_used_ex = 2'b01;
    mid(); chk("raw9b", 64'(stall), 64'd1);
    adv();
    rs_ex[4:0] = 5'd9; rs_used_ex = 2'b01; lw_valid = 1'b1; lw_rd = 5'd9;
    mid(); chk("lw_byp", 64'(fwd_sel[1:0]), 64'd3); chk("lw_byp_stall", 64'(stall), 64'd0);
    adv();
    mid(); chk("busy9_clr", 64'(busy_mask[9]), 64'd0); chk("cyc3", 64'(stall_cycles), 64'd3);
    adv();

    // Fill scoreboard x1..x4, then structural stall.
    for (int r = 1; r <= 4; r++) begin
      issue_long = 1'b1; issue_rd = 5'(r);
      mid(); adv();
    end
    issue_long = 1'b1; issue_rd = 5'd5;
    mid(); chk("struct_stall", 64'(stall), 64'd1); chk("struct_pend", 64'(pending_count), 64'd4);
    adv();
    issue_long = 1'b1; issue_rd = 5'd5; lw_valid = 1'b1; lw_rd = 5'd1;
    mid(); chk("struct_lw", 64'(stall), 64'd0);
    adv();
    mid(); chk("swap_pend", 64'(pending_count), 64'd4); chk("swap_mask", 64'(busy_mask), 64'h3C);
    adv();

    // WAW on x3, then flushed.
    lw_valid = 1'b1; lw_rd = 5'd2;
    mid(); adv();
    issue_long = 1'b1; issue_rd = 5'd3;
    mid(); chk("waw", 64'(stall), 64'd1); chk("waw_pend", 64'(pending_count), 64'd3);
    adv();
    issue_long = 1'b1; issue_rd = 5'd3; flush = 1'b1;
    mid(); chk("flush_stall", 64'(stall), 64'd0);
    adv();
    mid(); chk("flush_mask", 64'(busy_mask), 64'h38); chk("cyc5", 64'(stall_cycles), 64'd5);
    adv();

    // Orphan writeback sets sticky error.
    lw_valid = 1'b1; lw_rd = 5'd20;
    mid(); adv();
    mid(); chk("sb_err", 64'(sb_error), 64'd1); adv();
    mid(); adv();
    mid(); chk("sb_err_sticky", 64'(sb_error), 64'd1); chk("orphan_mask", 64'(busy_mask), 64'h38);
    adv();

    // Reset in the middle of a RAW stall with 3 pending.
    rs_ex[4:0] = 5'd3; rs_used_ex = 2'b01;
    mid(); chk("pre_rst_stall", 64'(stall), 64'd1);
    adv();
    rs_ex[4:0] = 5'd3; rs_used_ex = 2'b01; rst = 1'b1;
    mid(); chk("rst_stall", 64'(stall), 64'd0); chk("rst_cyc6", 64'(stall_cycles), 64'd6);
    adv();
    mid();
    chk("post_rst_mask", 64'(busy_mask), 64'd0); chk("post_rst_pend", 64'(pending_count), 64'd0);
    chk("post_rst_cyc", 64'(stall_cycles), 64'd0); chk("post_rst_err", 64'(sb_error), 64'd0);
    adv();

    // Saturation from a preloaded counter.
    force dut.stall_cycles = 32'hFFFF_FFFE;
    m_cyc = 64'hFFFF_FFFE;
    load_use7();
    #1 release dut.stall_cycles;
    mid(); chk("sat_pre", 64'(stall_cycles), 64'hFFFF_FFFE); chk("sat_stall", 64'(stall), 64'd1);
    adv();
    for (int n = 0; n < 3; n++) begin
      load_use7();
      mid(); adv();
    end
    mid(); chk("sat_hold", 64'(stall_cycles), 64'hFFFF_FFFF);
    chk("model_sat", m_cyc, 64'hFFFF_FFFF);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
